ysyx_trap_ctrl: RTL and testbench

//  Commit-side trap sequencer directly upstream of the CSR file. Takes one retiring instruction per

---
 rtl/ysyx_trap_ctrl_pkg.sv | 24 ++
 rtl/ysyx_trap_ctrl_if.sv | 69 ++++++
 rtl/ysyx_trap_irq_prio.sv | 36 +++
 rtl/ysyx_trap_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ysyx_trap_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_trap_ctrl_pkg.sv
// Shared types and constants for the commit-side trap sequencer.
// XLEN comes from the YSYX_XLEN macro and defaults to 32 when it is not set.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

package ysyx_trap_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        FLUSH = 2'd2
    } trap_state_t;

    localparam int unsigned IRQ_CODE_W   = 4;
    localparam int unsigned IRQ_CODE_MSI = 3;
    localparam int unsigned IRQ_CODE_MTI = 7;
    localparam int unsigned IRQ_CODE_MEI = 11;

    localparam int unsigned MIE_MSIE_BIT = 3;
    localparam int unsigned MIE_MTIE_BIT = 7;
    localparam int unsigned MIE_MEIE_BIT = 11;

endpackage

// File: rtl/ysyx_trap_ctrl_if.sv
// Commit, CSR-file and fetch-redirect signals of the trap sequencer.
// The sequencer itself uses the slave modport; its environment uses master.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

interface ysyx_trap_ctrl_if #(
    parameter int XLEN = `YSYX_XLEN,
    parameter int R_W  = 12
);
    logic            cmt_valid;
    logic            cmt_ready;
    logic [XLEN-1:0] cmt_pc;
    logic            cmt_ecall;
    logic            cmt_ebreak;
    logic            cmt_mret;
    logic            cmt_exc;
    logic [XLEN-1:0] cmt_cause;
    logic [XLEN-1:0] cmt_tval;
    logic            cmt_csr_wen;
    logic [R_W-1:0]  cmt_csr_waddr;
    logic [XLEN-1:0] cmt_csr_wdata;

    logic [XLEN-1:0] csr_mtvec;
    logic [XLEN-1:0] csr_mepc;
    logic            csr_mstatus_mie;
    logic [XLEN-1:0] csr_mie;
    logic            irq_msip;
    logic            irq_mtip;
    logic            irq_meip;

    logic            csr_valid;
    logic            csr_wen;
    logic            csr_ecall;
    logic            csr_mret;
    logic            csr_ebreak;
    logic            csr_trap;
    logic [R_W-1:0]  csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_pc;
    logic [XLEN-1:0] csr_cause;
    logic [XLEN-1:0] csr_tval;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic            flush_done;

    modport master (
        output cmt_valid, cmt_pc, cmt_ecall, cmt_ebreak, cmt_mret, cmt_exc,
               cmt_cause, cmt_tval, cmt_csr_wen, cmt_csr_waddr, cmt_csr_wdata,
               csr_mtvec, csr_mepc, csr_mstatus_mie, csr_mie,
               irq_msip, irq_mtip, irq_meip, flush_done,
        input  cmt_ready, csr_valid, csr_wen, csr_ecall, csr_mret, csr_ebreak,
               csr_trap, csr_waddr, csr_wdata, csr_pc, csr_cause, csr_tval,
               redirect_valid, redirect_pc, flush
    );

    modport slave (
        input  cmt_valid, cmt_pc, cmt_ecall, cmt_ebreak, cmt_mret, cmt_exc,
               cmt_cause, cmt_tval, cmt_csr_wen, cmt_csr_waddr, cmt_csr_wdata,
               csr_mtvec, csr_mepc, csr_mstatus_mie, csr_mie,
               irq_msip, irq_mtip, irq_meip, flush_done,
        output cmt_ready, csr_valid, csr_wen, csr_ecall, csr_mret, csr_ebreak,
               csr_trap, csr_waddr, csr_wdata, csr_pc, csr_cause, csr_tval,
               redirect_valid, redirect_pc, flush
    );

endinterface

// File: rtl/ysyx_trap_irq_prio.sv
// Machine interrupt priority encoder: MEI > MSI > MTI, gated by mstatus.MIE
// and the matching mie enable bit.
module ysyx_trap_irq_prio
    import ysyx_trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  mstatus_mie,
    input  logic [XLEN-1:0]       mie,
    input  logic                  irq_msip,
    input  logic                  irq_mtip,
    input  logic                  irq_meip,
    output logic                  pend,
    output logic [IRQ_CODE_W-1:0] code
);

    logic mei;
    logic msi;
    logic mti;

    assign mei = irq_meip & |(mie & (XLEN'(1) << MIE_MEIE_BIT));
    assign msi = irq_msip & |(mie & (XLEN'(1) << MIE_MSIE_BIT));
    assign mti = irq_mtip & |(mie & (XLEN'(1) << MIE_MTIE_BIT));

    always_comb begin
        pend = mstatus_mie & (mei | msi | mti);
        code = '0;
        if (mei)
            code = IRQ_CODE_W'(IRQ_CODE_MEI);
        else if (msi)
            code = IRQ_CODE_W'(IRQ_CODE_MSI);
        else if (mti)
            code = IRQ_CODE_W'(IRQ_CODE_MTI);
    end

endmodule

// File: rtl/ysyx_trap_ctrl.sv
// Commit-side trap sequencer feeding the CSR file and redirecting fetch.
// Define YSYX_TRAP_VECTORED_EN to honour vectored mtvec mode for interrupts.
//
// state | meaning
// IDLE  | accepting commits; plain instructions retire back-to-back
// REDIR | one cycle: fetch redirect issued, flush raised
// FLUSH | flush held, commit stalled until flush_done
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_trap_ctrl
    import ysyx_trap_ctrl_pkg::*;
#(
    parameter int XLEN = `YSYX_XLEN,
    parameter int R_W  = 12
) (
    input  logic              clock,
    input  logic              reset,
    ysyx_trap_ctrl_if.slave   ctl
);

    trap_state_t state;
    trap_state_t state_nxt;

    logic                  hs;
    logic                  irq_pend;
    logic [IRQ_CODE_W-1:0] irq_code;
    logic                  trap_evt;
    logic                  take_mret;
    logic [XLEN-1:0]       trap_base;

    logic            ready_q,  ready_nxt;
    logic            valid_q,  valid_nxt;
    logic            wen_q,    wen_nxt;
    logic            ecall_q,  ecall_nxt;
    logic            ebreak_q, ebreak_nxt;
    logic            mret_q,   mret_nxt;
    logic            trap_q,   trap_nxt;
    logic [R_W-1:0]  waddr_q,  waddr_nxt;
    logic [XLEN-1:0] wdata_q,  wdata_nxt;
    logic [XLEN-1:0] pc_q,     pc_nxt;
    logic [XLEN-1:0] cause_q,  cause_nxt;
    logic [XLEN-1:0] tval_q,   tval_nxt;
    logic            rdir_q,   rdir_nxt;
    logic [XLEN-1:0] rpc_q,    rpc_nxt;
    logic            flush_q,  flush_nxt;

    ysyx_trap_irq_prio #(.XLEN(XLEN)) u_irq_prio (
        .mstatus_mie (ctl.csr_mstatus_mie),
        .mie         (ctl.csr_mie),
        .irq_msip    (ctl.irq_msip),
        .irq_mtip    (ctl.irq_mtip),
        .irq_meip    (ctl.irq_meip),
        .pend        (irq_pend),
        .code        (irq_code)
    );

    assign hs        = ctl.cmt_valid & ready_q;
    assign trap_evt  = irq_pend | ctl.cmt_exc | ctl.cmt_ecall | ctl.cmt_ebreak | ctl.cmt_mret;
    assign take_mret = ctl.cmt_mret & ~(irq_pend | ctl.cmt_exc | ctl.cmt_ecall | ctl.cmt_ebreak);
    assign trap_base = ctl.csr_mtvec & ~XLEN'(3);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs && trap_evt) state_nxt = REDIR;
            REDIR:   state_nxt = FLUSH;
            FLUSH:   if (ctl.flush_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_nxt  = 1'b0;
        wen_nxt    = 1'b0;
        ecall_nxt  = 1'b0;
        ebreak_nxt = 1'b0;
        mret_nxt   = 1'b0;
        trap_nxt   = 1'b0;
        waddr_nxt  = waddr_q;
        wdata_nxt  = wdata_q;
        pc_nxt     = pc_q;
        cause_nxt  = cause_q;
        tval_nxt   = tval_q;
        rpc_nxt    = rpc_q;
        if (hs) begin
            valid_nxt = 1'b1;
            pc_nxt    = ctl.cmt_pc;
            waddr_nxt = ctl.cmt_csr_waddr;
            wdata_nxt = ctl.cmt_csr_wdata;
            cause_nxt = '0;
            tval_nxt  = '0;
            if (irq_pend) begin
                trap_nxt  = 1'b1;
                cause_nxt = {1'b1, (XLEN-1)'(irq_code)};
            end else if (ctl.cmt_exc) begin
                trap_nxt  = 1'b1;
                cause_nxt = ctl.cmt_cause;
                tval_nxt  = ctl.cmt_tval;
            end else if (ctl.cmt_ecall) begin
                ecall_nxt = 1'b1;
            end else if (ctl.cmt_ebreak) begin
                ebreak_nxt = 1'b1;
            end else if (ctl.cmt_mret) begin
                mret_nxt = 1'b1;
            end else begin
                wen_nxt = ctl.cmt_csr_wen;
            end
            // mret returns to mepc as it stands before this cycle's CSR update
            if (take_mret)
                rpc_nxt = ctl.csr_mepc;
            else if (trap_evt) begin
                rpc_nxt = trap_base;
`ifdef YSYX_TRAP_VECTORED_EN
                if (irq_pend && ctl.csr_mtvec[1:0] == 2'b01)
                    rpc_nxt = trap_base + XLEN'({irq_code, 2'b00});
`endif
            end
        end
        ready_nxt = (state_nxt == IDLE);
        rdir_nxt  = (state_nxt == REDIR);
        flush_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            wen_q    <= 1'b0;
            ecall_q  <= 1'b0;
            ebreak_q <= 1'b0;
            mret_q   <= 1'b0;
            trap_q   <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            pc_q     <= '0;
            cause_q  <= '0;
            tval_q   <= '0;
            rdir_q   <= 1'b0;
            rpc_q    <= '0;
            flush_q  <= 1'b0;
        end else begin
            ready_q  <= ready_nxt;
            valid_q  <= valid_nxt;
            wen_q    <= wen_nxt;
            ecall_q  <= ecall_nxt;
            ebreak_q <= ebreak_nxt;
            mret_q   <= mret_nxt;
            trap_q   <= trap_nxt;
            waddr_q  <= waddr_nxt;
            wdata_q  <= wdata_nxt;
            pc_q     <= pc_nxt;
            cause_q  <= cause_nxt;
            tval_q   <= tval_nxt;
            rdir_q   <= rdir_nxt;
            rpc_q    <= rpc_nxt;
            flush_q  <= flush_nxt;
        end
    end

    assign ctl.cmt_ready      = ready_q;
    assign ctl.csr_valid      = valid_q;
    assign ctl.csr_wen        = wen_q;
    assign ctl.csr_ecall      = ecall_q;
    assign ctl.csr_ebreak     = ebreak_q;
    assign ctl.csr_mret       = mret_q;
    assign ctl.csr_trap       = trap_q;
    assign ctl.csr_waddr      = waddr_q;
    assign ctl.csr_wdata      = wdata_q;
    assign ctl.csr_pc         = pc_q;
    assign ctl.csr_cause      = cause_q;
    assign ctl.csr_tval       = tval_q;
    assign ctl.redirect_valid = rdir_q;
    assign ctl.redirect_pc    = rpc_q;
    assign ctl.flush          = flush_q;

endmodule

// File: tb/tb_ysyx_trap_ctrl.sv
// Self-checking bench for ysyx_trap_ctrl: directed scenarios, then random
// commits compared against a rule-level reference model.
module tb_ysyx_trap_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic        ecall, ebreak, mret, exc;
        logic [31:0] cause, tval;
        logic        wen;
        logic [11:0] waddr;
        logic [31:0] wdata, mtvec, mepc;
        logic        mstatus_mie;
        logic [31:0] mie;
        logic        msip, mtip, meip;
    } txn_t;

    typedef struct {
        logic        trap, ecall, ebreak, mret, wen, redir;
        logic [31:0] cause, tval, target;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] obs_cause, obs_tval, obs_pc, obs_rpc;
    logic        raise_mtip_in_redir = 1'b0;

    always #5 clock = ~clock;

    ysyx_trap_ctrl_if bus ();

    ysyx_trap_ctrl dut (
        .clock (clock),
        .reset (reset),
        .ctl   (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input txn_t t);
        exp_t        e;
        int          code;
        int          codes[3];
        logic        src[3];
        logic [31:0] base;
        e = '{default: '0};
        codes = '{11, 3, 7};
        src   = '{t.meip, t.msip, t.mtip};
        code  = -1;
        if (t.mstatus_mie)
            for (int k = 0; k < 3; k++)
                if (code < 0 && src[k] && t.mie[codes[k]]) code = codes[k];
        base = t.mtvec & 32'hFFFF_FFFC;
        if (code >= 0) begin
            e.trap = 1'b1; e.redir = 1'b1;
            e.cause = 32'h8000_0000 | 32'(code);
            e.target = base;
`ifdef YSYX_TRAP_VECTORED_EN
            if (t.mtvec[1:0] == 2'b01) e.target = base + 32'(4 * code);
`endif
        end else if (t.exc) begin
            e.trap = 1'b1; e.redir = 1'b1;
            e.cause = t.cause; e.tval = t.tval; e.target = base;
        end else if (t.ecall) begin
            e.ecall = 1'b1; e.redir = 1'b1; e.target = base;
        end else if (t.ebreak) begin
            e.ebreak = 1'b1; e.redir = 1'b1; e.target = base;
        end else if (t.mret) begin
            e.mret = 1'b1; e.redir = 1'b1; e.target = t.mepc;
        end else begin
            e.wen = t.wen;
        end
        return e;
    endfunction

    task automatic apply(input txn_t t);
        bus.cmt_pc          = t.pc;
        bus.cmt_ecall       = t.ecall;
        bus.cmt_ebreak      = t.ebreak;
        bus.cmt_mret        = t.mret;
        bus.cmt_exc         = t.exc;
        bus.cmt_cause       = t.cause;
        bus.cmt_tval        = t.tval;
        bus.cmt_csr_wen     = t.wen;
        bus.cmt_csr_waddr   = t.waddr;
        bus.cmt_csr_wdata   = t.wdata;
        bus.csr_mtvec       = t.mtvec;
        bus.csr_mepc        = t.mepc;
        bus.csr_mstatus_mie = t.mstatus_mie;
        bus.csr_mie         = t.mie;
        bus.irq_msip        = t.msip;
        bus.irq_mtip        = t.mtip;
        bus.irq_meip        = t.meip;
    endtask

    function automatic txn_t plain_txn();
        txn_t t;
        t = '{default: '0};
        t.pc = 32'h8000_0000;
        t.mtvec = 32'h8000_0004;
        return t;
    endfunction

    // Issue one commit and follow it through strobes, redirect and flush.
    task automatic do_commit(input txn_t t);
        exp_t e;
        int   d;
        e = model(t);
        apply(t);
        bus.cmt_valid = 1'b1;
        check_eq("ready_before", 64'(bus.cmt_ready), 64'(1'b1));
        @(posedge clock); #1;
        bus.cmt_valid = 1'b0;
        obs_cause = bus.csr_cause; obs_tval = bus.csr_tval;
        obs_pc = bus.csr_pc; obs_rpc = bus.redirect_pc;
        check_eq("csr_valid", 64'(bus.csr_valid), 64'(1'b1));
        check_eq("csr_trap", 64'(bus.csr_trap), 64'(e.trap));
        check_eq("csr_ecall", 64'(bus.csr_ecall), 64'(e.ecall));
        check_eq("csr_ebreak", 64'(bus.csr_ebreak), 64'(e.ebreak));
        check_eq("csr_mret", 64'(bus.csr_mret), 64'(e.mret));
        check_eq("csr_wen", 64'(bus.csr_wen), 64'(e.wen));
        check_eq("redirect_valid", 64'(bus.redirect_valid), 64'(e.redir));
        if (e.trap) begin
            check_eq("csr_cause", 64'(bus.csr_cause), 64'(e.cause));
            check_eq("csr_tval", 64'(bus.csr_tval), 64'(e.tval));
        end
        if (e.redir) begin
            check_eq("csr_pc", 64'(bus.csr_pc), 64'(t.pc));
            check_eq("redirect_pc", 64'(bus.redirect_pc), 64'(e.target));
            check_eq("flush_redir", 64'(bus.flush), 64'(1'b1));
            check_eq("ready_redir", 64'(bus.cmt_ready), 64'(1'b0));
            d = $urandom_range(0, 3);
            bus.flush_done = 1'($urandom_range(0, 1));
            if (raise_mtip_in_redir) bus.irq_mtip = 1'b1;
            @(posedge clock); #1;
            bus.flush_done = 1'b0;
            check_eq("csr_valid_flush", 64'(bus.csr_valid), 64'(1'b0));
            check_eq("redirect_once", 64'(bus.redirect_valid), 64'(1'b0));
            check_eq("flush_held", 64'(bus.flush), 64'(1'b1));
            check_eq("ready_flush", 64'(bus.cmt_ready), 64'(1'b0));
            for (int k = 0; k < d; k++) begin
                @(posedge clock); #1;
                check_eq("flush_wait", 64'(bus.flush), 64'(1'b1));
                check_eq("ready_wait", 64'(bus.cmt_ready), 64'(1'b0));
                check_eq("no_dup_strobe", 64'(bus.csr_valid), 64'(1'b0));
            end
            bus.flush_done = 1'b1;
            @(posedge clock); #1;
            bus.flush_done = 1'b0;
            check_eq("ready_after", 64'(bus.cmt_ready), 64'(1'b1));
            check_eq("flush_after", 64'(bus.flush), 64'(1'b0));
        end else begin
            if (e.wen) begin
                check_eq("csr_waddr", 64'(bus.csr_waddr), 64'(t.waddr));
                check_eq("csr_wdata", 64'(bus.csr_wdata), 64'(t.wdata));
            end
            check_eq("flush_plain", 64'(bus.flush), 64'(1'b0));
            check_eq("ready_plain", 64'(bus.cmt_ready), 64'(1'b1));
        end
    endtask

    // Start an ecall and pulse reset after `cycles` cycles in REDIR/FLUSH.
    task automatic reset_mid_trap(input int cycles);
        txn_t t;
        t = plain_txn();
        t.ecall = 1'b1;
        apply(t);
        bus.cmt_valid = 1'b1;
        @(posedge clock); #1;
        bus.cmt_valid = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        #1;
        check_eq("rst_flush", 64'(bus.flush), 64'(1'b0));
        check_eq("rst_redirect", 64'(bus.redirect_valid), 64'(1'b0));
        check_eq("rst_csr_valid", 64'(bus.csr_valid), 64'(1'b0));
        check_eq("rst_csr_pc", 64'(bus.csr_pc), 64'(0));
        check_eq("rst_redirect_pc", 64'(bus.redirect_pc), 64'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check_eq("rst_ready", 64'(bus.cmt_ready), 64'(1'b1));
        check_eq("rst_flush_after", 64'(bus.flush), 64'(1'b0));
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        int   r;
        t.pc     = $urandom() & 32'hFFFF_FFFC;
        r        = $urandom_range(0, 9);
        t.ecall  = (r == 0);
        t.ebreak = (r == 1);
        t.mret   = (r == 2);
        t.exc    = (r == 3) || ($urandom_range(0, 7) == 0);
        t.cause  = $urandom();
        t.tval   = $urandom();
        t.wen    = 1'($urandom_range(0, 1));
        t.waddr  = 12'($urandom());
        t.wdata  = $urandom();
        t.mtvec  = $urandom();
        t.mepc   = $urandom();
        t.mstatus_mie = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0: t.mie = 32'h0000_0888;
            1: t.mie = 32'h0000_0080;
            2: t.mie = 32'h0000_0008;
            default: t.mie = $urandom();
        endcase
        t.msip = ($urandom_range(0, 3) == 0);
        t.mtip = ($urandom_range(0, 3) == 0);
        t.meip = ($urandom_range(0, 3) == 0);
        return t;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        bus.cmt_valid  = 1'b0;
        bus.flush_done = 1'b0;
        apply(plain_txn());

        repeat (2) @(posedge clock);
        #1;
        check_eq("reset_valid", 64'(bus.csr_valid), 64'(1'b0));
        check_eq("reset_trap", 64'(bus.csr_trap), 64'(1'b0));
        check_eq("reset_redirect", 64'(bus.redirect_valid), 64'(1'b0));
        check_eq("reset_flush", 64'(bus.flush), 64'(1'b0));
        check_eq("reset_csr_pc", 64'(bus.csr_pc), 64'(0));
        check_eq("reset_cause", 64'(bus.csr_cause), 64'(0));
        reset = 1'b0;
        @(posedge clock); #1;
        check_eq("ready_idle", 64'(bus.cmt_ready), 64'(1'b1));

        // plain csrrw twice back-to-back
        t = plain_txn();
        t.wen = 1'b1; t.waddr = 12'h340; t.wdata = 32'h55;
        do_commit(t);
        t.wdata = 32'h66;
        do_commit(t);

        // ecall
        t = plain_txn();
        t.ecall = 1'b1; t.pc = 32'h8000_0100; t.mtvec = 32'h8000_0004;
        do_commit(t);
        check_eq("t2_csr_pc", 64'(obs_pc), 64'(32'h8000_0100));
        check_eq("t2_redirect_pc", 64'(obs_rpc), 64'(32'h8000_0004));

        // mret with a CSR write attached
        t = plain_txn();
        t.mret = 1'b1; t.mepc = 32'h8000_0200; t.wen = 1'b1;
        do_commit(t);
        check_eq("t3_redirect_pc", 64'(obs_rpc), 64'(32'h8000_0200));

        // interrupt priority
        t = plain_txn();
        t.mstatus_mie = 1'b1; t.mtip = 1'b1; t.meip = 1'b1; t.mie = 32'h880;
        t.tval = 32'hDEAD_BEEF;
        do_commit(t);
        check_eq("t4_cause_mei", 64'(obs_cause), 64'(32'h8000_000B));
        check_eq("t4_tval", 64'(obs_tval), 64'(0));
        t.mie = 32'h080;
        do_commit(t);
        check_eq("t4_cause_mti", 64'(obs_cause), 64'(32'h8000_0007));

        // vectored mtvec with MTI
        t = plain_txn();
        t.mstatus_mie = 1'b1; t.mtip = 1'b1; t.mie = 32'h080; t.mtvec = 32'h8000_1001;
        do_commit(t);
`ifdef YSYX_TRAP_VECTORED_EN
        check_eq("t5_vectored", 64'(obs_rpc), 64'(32'h8000_101C));
`else
        check_eq("t5_direct", 64'(obs_rpc), 64'(32'h8000_1000));
`endif

        // interrupt rising during REDIR is taken by the next commit only
        t = plain_txn();
        t.ecall = 1'b1; t.mstatus_mie = 1'b1; t.mie = 32'h080;
        raise_mtip_in_redir = 1'b1;
        do_commit(t);
        raise_mtip_in_redir = 1'b0;
        t.ecall = 1'b0; t.mtip = 1'b1;
        do_commit(t);
        check_eq("held_irq_cause", 64'(obs_cause), 64'(32'h8000_0007));

        // reset in REDIR and in FLUSH
        reset_mid_trap(0);
        reset_mid_trap(1);

        // faulting instruction never writes a CSR
        t = plain_txn();
        t.exc = 1'b1; t.cause = 32'h2; t.tval = 32'h1234; t.wen = 1'b1;
        do_commit(t);

        for (int i = 0; i < 300; i++)
            do_commit(rand_txn());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
